// File: rtl/inst_loader_pkg.sv
// Shared constants and types for the boot-time instruction loader.
// The frame is a length byte (word count), a little-endian payload, then an XOR checksum byte.
package inst_loader_pkg;

   localparam int MEM_BYTES      = 256;
   localparam int BYTES_PER_WORD = 4;
   localparam int MAX_WORDS      = MEM_BYTES / BYTES_PER_WORD;
   localparam int ADDR_W         = $clog2(MEM_BYTES);
   localparam int CNT_W          = ADDR_W + 1;

   localparam logic [7:0] CSUM_SEED = 8'h00;
   localparam logic [7:0] FILL_BYTE = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_FILL = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_e;

   // A length byte is usable when it names 1..MAX_WORDS words.
   function automatic logic len_ok(input logic [7:0] n);
      return (n != 8'd0) && (n <= 8'(MAX_WORDS));
   endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte stream in (valid/ready) and byte write port out of the loader.
// Handshake: a byte transfers in any cycle where in_valid && in_ready; in_ready never depends on in_valid.
interface inst_loader_if;
   import inst_loader_pkg::*;

   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_waddr, mem_wdata
   );

endinterface

// File: rtl/inst_loader.sv
// Parses a framed program image from the byte stream into the instruction store,
// zero-fills the unused tail and releases the CPU only after a matching checksum.
module inst_loader
   import inst_loader_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   inst_loader_if.slave lif,
   output logic         cpu_run,
   output logic         err,
   output logic         busy,
   output state_e       dbg_state_o
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  total_q;
   logic [7:0]        xor_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [7:0]        wdata_q;
   logic              cpu_run_q;
   logic              err_q;

   logic              accept;
   logic [CNT_W-1:0]  cnt_d;
   logic [7:0]        xor_d;

   assign lif.in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign busy         = lif.in_ready || (state_q == ST_FILL);
   assign accept       = lif.in_valid && lif.in_ready;
   assign cnt_d        = cnt_q + CNT_W'(1);
   assign xor_d        = xor_q ^ lif.in_data;

   assign lif.mem_we    = mem_we_q;
   assign lif.mem_waddr = waddr_q;
   assign lif.mem_wdata = wdata_q;
   assign cpu_run       = cpu_run_q;
   assign err           = err_q;
   assign dbg_state_o   = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         total_q   <= '0;
         xor_q     <= CSUM_SEED;
         mem_we_q  <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         cpu_run_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state_q   <= ST_LEN;
                  cnt_q     <= '0;
                  xor_q     <= CSUM_SEED;
                  cpu_run_q <= 1'b0;
                  err_q     <= 1'b0;
               end
            end
            ST_LEN: begin
               if (accept) begin
                  if (len_ok(lif.in_data)) begin
                     // N <= 64, so 4*N fits the 9-bit counter without bit 7 of N.
                     total_q <= {lif.in_data[6:0], 2'b00};
                     state_q <= ST_DATA;
                  end else begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            ST_DATA: begin
               if (accept) begin
                  mem_we_q <= 1'b1;
                  waddr_q  <= cnt_q[ADDR_W-1:0];
                  wdata_q  <= lif.in_data;
                  xor_q    <= xor_d;
                  cnt_q    <= cnt_d;
                  if (cnt_d == total_q) state_q <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (accept) begin
                  if (lif.in_data != xor_q) begin
                     state_q <= ST_ERR;
                     err_q   <= 1'b1;
                  end else if (total_q == CNT_W'(MEM_BYTES)) begin
                     state_q   <= ST_DONE;
                     cpu_run_q <= 1'b1;
                  end else begin
                     // cnt already equals total here: the tail starts right after the payload.
                     state_q <= ST_FILL;
                  end
               end
            end
            ST_FILL: begin
               mem_we_q <= 1'b1;
               waddr_q  <= cnt_q[ADDR_W-1:0];
               wdata_q  <= FILL_BYTE;
               cnt_q    <= cnt_d;
               if (cnt_q == CNT_W'(MEM_BYTES - 1)) begin
                  state_q   <= ST_DONE;
                  cpu_run_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time loader that fills the byte-addressed instruction memory from an 8-bit valid/ready byte stream (UART receiver or testbench) before the CPU starts. It parses a framed program image (length byte, little-endian payload, XOR checksum), writes each payload byte through the memory's byte write port, and zero-fills the unused tail. It releases the CPU via `cpu_run` only after a good checksum. It is the write-side counterpart to the read-only fetch port of the 256-byte instruction store.

## Interface
- `MEM_BYTES`, 256: instruction store size in bytes; address width is log2, so 8 bits.
- `MAX_WORDS`, 64: largest accepted program, equal to MEM_BYTES/4.
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `start`  in  1: one-cycle pulse that begins a load. Honoured in IDLE, DONE and ERR; ignored otherwise.
- `in_valid`  in  1: stream byte valid.
- `in_data`  in  8: stream byte.
- `in_ready`  out  1: loader can accept a byte.
- `mem_we`  out  1: byte write strobe to the instruction store.
- `mem_waddr`  out  8: byte address.
- `mem_wdata`  out  8: byte data.
- `cpu_run`  out  1: image loaded and verified; CPU may fetch.
- `err`  out  1: frame rejected (bad length or bad checksum).
- `busy`  out  1: load in progress (states LEN, DATA, CSUM, FILL).

## Operation
- States: IDLE, LEN, DATA, CSUM, FILL, DONE, ERR.
- A byte is accepted in a cycle where `in_valid && in_ready`. `in_ready` is 1 only in LEN, DATA and CSUM.
- IDLE: on `start`, go to LEN. Clear the byte counter and the XOR accumulator.
- LEN: the accepted byte is N, the word count.
  - N = 0 or N > MAX_WORDS: go to ERR.
  - Otherwise latch `total = 4*N` (9-bit) and go to DATA.
- DATA: each accepted byte produces a write to address `cnt`.
  - Update `xor ^= byte` and `cnt += 1`.
  - After byte `total-1`, go to CSUM.
  - Byte k lands at address k, so word i is assembled little-endian: byte 4i is the LSB.
- CSUM: the accepted byte is compared with `xor`.
  - Mismatch: go to ERR.
  - Match with `total == 256`: go to DONE.
  - Match otherwise: go to FILL with `cnt = total`.
- FILL: write 0x00 to address `cnt` once per cycle, with no stream interaction. After address 255 is written, go to DONE.
- DONE: `cpu_run = 1`. `start` restarts the load (go to LEN) and drops `cpu_run` in the same cycle.
- ERR: `err = 1`, `cpu_run = 0`. `start` clears `err` and goes to LEN.
- Counter is 9 bits internally; `mem_waddr` is its low 8 bits. The address never wraps because total ≤ 256.
- Checksum covers payload bytes only. The length byte and the checksum byte are excluded.
- Writes already performed before an ERR or a reset are not undone.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `cpu_run`, `err`, `busy` = 0; `mem_waddr`, `mem_wdata` = 0.
- Write outputs are registered. A byte accepted in cycle t appears as `mem_we=1` with its address and data in cycle t+1.
- One byte per cycle sustained throughput. `in_ready` stays high through back-to-back bytes in LEN/DATA/CSUM.
- FILL writes one byte per cycle: a load of N words occupies 256−4N FILL cycles.
- `cpu_run` and `err` are registered. Each rises the cycle after the state transition that sets it.
- `rst` overrides everything, including mid-frame and mid-FILL: next cycle is IDLE with all outputs at their reset values.
- `start` asserted during LEN, DATA, CSUM or FILL is ignored.
- `in_valid` in any state without `in_ready` is ignored; no byte is consumed.

## Structure
- Shared package holds:
  - State enum encoding (3 bits).
  - `MEM_BYTES`, `MAX_WORDS`, address width.
  - Frame field constants, including the checksum seed 0x00.
- A single module. No sub-module needed: FSM, counter, XOR accumulator and registered write port fit in one block.

## Test plan
- **Single-word load.** Reset, `start`, then bytes 0x01, 0x03, 0x00, 0x08, 0x21, checksum 0x2A.
  - Writes at addresses 0..3 carry 03/00/08/21.
  - Then 252 zero writes at addresses 4..255.
  - `cpu_run`=1; a read of word 0 returns 0x21080003.
- **Bad checksum.** Same frame with checksum 0x2B → `err`=1, no FILL writes, `cpu_run`=0. A following `start` plus a good frame → DONE.
- **Length boundaries.**
  - N=0 → ERR immediately.
  - N=65 → ERR immediately.
  - N=64 (256 payload bytes, good checksum) → DONE with no FILL cycles; last write at address 255.
- **Backpressure and gaps.** Drive `in_valid` with random idle cycles for N=3.
  - Exactly 12 payload writes, in order, to addresses 0..11.
  - `in_ready` never drops mid-frame.
- **Reset mid-DATA.** Assert `rst` after 5 payload bytes → next cycle IDLE, all outputs 0. A `start` while in DATA is ignored.
- **Reload from DONE.** `start` in DONE → `cpu_run` falls; a new 2-word image loads and `cpu_run` rises again after FILL completes.
